// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 row capture block.
// Holds the sub-pixel bit positions inside the 6-bit panel_rgb bus,
// the default geometry and the capture FSM state encoding.
package hub75_pkg;

  // Bit positions of each sub-pixel on panel_rgb = {b1,g1,r1,b0,g0,r0}.
  localparam int R0 = 0;
  localparam int G0 = 1;
  localparam int B0 = 2;
  localparam int R1 = 3;
  localparam int G1 = 4;
  localparam int B1 = 5;

  localparam int RGB_W = 6;

  // Default geometry: one 64-pixel chain, 16 scan rows.
  localparam int DEF_COLS      = 64;
  localparam int DEF_ROW_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // waiting for a row latch
    ST_WAIT_OE = 2'd1,  // row latched, waiting for output enable
    ST_MEASURE = 2'd2,  // timing the OE high pulse
    ST_DUMP    = 2'd3   // streaming the row record
  } state_e;

endpackage

// File: rtl/hub75_input_sync.sv
// Synchronizer and edge detector for the asynchronous HUB75 panel inputs.
// Every input goes through SYNC_STAGES flops (SYNC_STAGES must be >= 2).
// Edges are formed from the last stage against a one-cycle delayed copy and
// registered once more; the data bus is registered in the same flop so each
// edge pulse is accompanied by the data that was present when it occurred.
//
// Ports:
//   clk_i, rst_ni         system clock, async active-low reset
//   pclk_i, latch_i, oe_i raw panel strobes
//   data_i                raw panel data (row address + rgb)
//   pclk_rise_o           one-cycle pulse on a pixel clock rise
//   latch_rise_o          one-cycle pulse on a latch rise
//   oe_rise_o, oe_fall_o  one-cycle pulses on output-enable edges
//   oe_level_o            synchronized OE level, aligned with the edge pulses
//   data_o                synchronized data, aligned with the edge pulses
module hub75_input_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pclk_i,
  input  logic              latch_i,
  input  logic              oe_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              pclk_rise_o,
  output logic              latch_rise_o,
  output logic              oe_rise_o,
  output logic              oe_fall_o,
  output logic              oe_level_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int W = DATA_W + 3;

  // Packed as {pclk, latch, oe, data}.
  logic [W-1:0]      stage_q [SYNC_STAGES];
  logic [W-1:0]      last;
  logic              pclk_prev_q, latch_prev_q, oe_prev_q;
  logic              pclk_rise_q, latch_rise_q, oe_rise_q, oe_fall_q, oe_level_q;
  logic [DATA_W-1:0] data_q;

  assign last = stage_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      pclk_prev_q  <= 1'b0;
      latch_prev_q <= 1'b0;
      oe_prev_q    <= 1'b0;
      pclk_rise_q  <= 1'b0;
      latch_rise_q <= 1'b0;
      oe_rise_q    <= 1'b0;
      oe_fall_q    <= 1'b0;
      oe_level_q   <= 1'b0;
      data_q       <= '0;
    end else begin
      // NOTE: every register here uses <= so all stages read their
      // pre-edge values; blocking assignments would collapse the chain.
      stage_q[0] <= {pclk_i, latch_i, oe_i, data_i};
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      pclk_prev_q  <= last[W-1];
      latch_prev_q <= last[W-2];
      oe_prev_q    <= last[W-3];
      pclk_rise_q  <= last[W-1] & ~pclk_prev_q;
      latch_rise_q <= last[W-2] & ~latch_prev_q;
      oe_rise_q    <= last[W-3] & ~oe_prev_q;
      oe_fall_q    <= ~last[W-3] & oe_prev_q;
      oe_level_q   <= last[W-3];
      data_q       <= last[DATA_W-1:0];
    end
  end

  assign pclk_rise_o  = pclk_rise_q;
  assign latch_rise_o = latch_rise_q;
  assign oe_rise_o    = oe_rise_q;
  assign oe_fall_o    = oe_fall_q;
  assign oe_level_o   = oe_level_q;
  assign data_o       = data_q;

endmodule

// File: rtl/hub75_row_capture.sv
// HUB75 panel receiver: rebuilds each latched row of 6-bit pixels, measures
// the output-enable pulse width in clk_in cycles and streams one record per
// row (COLS beats, column COLS-1 first) over a valid/ready port.
//
// Ports:
//   clk_in, reset        system clock (>= 4x pixel clock), async active-low reset
//   panel_clk/rgb/latch/oe/row   raw HUB75 inputs
//   out_valid/ready/col/rgb/last stream beat handshake and payload
//   out_row, out_oe_cycles       record header, stable for the whole record
//   pix_count                    pixel clocks seen before the last accepted latch
//   err_overrun, err_length      sticky error flags
module hub75_row_capture
  import hub75_pkg::*;
#(
  parameter int COLS         = DEF_COLS,
  parameter int ROW_WIDTH    = DEF_ROW_WIDTH,
  parameter int OE_CNT_WIDTH = 10,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    panel_clk,
  input  logic [RGB_W-1:0]        panel_rgb,
  input  logic                    panel_latch,
  input  logic                    panel_oe,
  input  logic [ROW_WIDTH-1:0]    panel_row,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(COLS)-1:0] out_col,
  output logic [RGB_W-1:0]        out_rgb,
  output logic                    out_last,
  output logic [ROW_WIDTH-1:0]    out_row,
  output logic [OE_CNT_WIDTH-1:0] out_oe_cycles,
  output logic [$clog2(COLS):0]   pix_count,
  output logic                    err_overrun,
  output logic                    err_length
);

  localparam int COL_W = $clog2(COLS);
  localparam int PC_W  = COL_W + 1;
  localparam logic [PC_W-1:0] PIX_FULL = PC_W'(COLS);
  localparam logic [PC_W-1:0] PIX_MAX  = PC_W'(COLS + 1);

  logic                    pclk_rise, latch_rise, oe_rise, oe_fall, oe_level;
  logic [ROW_WIDTH+RGB_W-1:0] sync_data;
  logic [RGB_W-1:0]        rgb_s;
  logic [ROW_WIDTH-1:0]    row_s;

  hub75_input_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .DATA_W     (ROW_WIDTH + RGB_W)
  ) u_sync (
    .clk_i       (clk_in),
    .rst_ni      (reset),
    .pclk_i      (panel_clk),
    .latch_i     (panel_latch),
    .oe_i        (panel_oe),
    .data_i      ({panel_row, panel_rgb}),
    .pclk_rise_o (pclk_rise),
    .latch_rise_o(latch_rise),
    .oe_rise_o   (oe_rise),
    .oe_fall_o   (oe_fall),
    .oe_level_o  (oe_level),
    .data_o      (sync_data)
  );

  assign rgb_s = {sync_data[B1], sync_data[G1], sync_data[R1],
                  sync_data[B0], sync_data[G0], sync_data[R0]};
  assign row_s = sync_data[RGB_W +: ROW_WIDTH];

  state_e                  state_q, state_d;
  logic [RGB_W-1:0]        shift_q [COLS];
  logic [RGB_W-1:0]        hold_q  [COLS];
  logic [PC_W-1:0]         pix_cnt_q, pix_cnt_d;
  logic [PC_W-1:0]         pix_count_q;
  logic [OE_CNT_WIDTH-1:0] oe_cnt_q, oe_cycles_q;
  logic [ROW_WIDTH-1:0]    row_q;
  logic [COL_W-1:0]        idx_q;
  logic                    err_overrun_q, err_length_q;

  // Pixel count including a pixel clock that lands in the same cycle as the
  // latch, so a simultaneous last pixel is counted in the copied value.
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    if (pclk_rise && pix_cnt_q != PIX_MAX) pix_cnt_d = pix_cnt_q + 1'b1;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (latch_rise) state_d = ST_WAIT_OE;
      ST_WAIT_OE: if (oe_rise)    state_d = ST_MEASURE;
      ST_MEASURE: if (oe_fall)    state_d = ST_DUMP;
      ST_DUMP:    if (out_ready && idx_q == '0) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      // NOTE: the pixel arrays are cleared too, so a reset leaves no stale
      // row to be streamed by a later record.
      for (int i = 0; i < COLS; i++) begin
        shift_q[i] <= '0;
        hold_q[i]  <= '0;
      end
      pix_cnt_q     <= '0;
      pix_count_q   <= '0;
      oe_cnt_q      <= '0;
      oe_cycles_q   <= '0;
      row_q         <= '0;
      idx_q         <= '0;
      err_overrun_q <= 1'b0;
      err_length_q  <= 1'b0;
    end else begin
      // Shift capture runs regardless of state; newest pixel at index 0.
      if (pclk_rise) begin
        shift_q[0] <= rgb_s;
        for (int i = 1; i < COLS; i++) shift_q[i] <= shift_q[i-1];
      end

      if (latch_rise) begin
        pix_cnt_q <= '0;
        if (state_q == ST_IDLE) begin
          pix_count_q <= pix_cnt_d;
          if (pix_cnt_d != PIX_FULL) err_length_q <= 1'b1;
          // Copy the post-shift view so a coincident pixel clock is included.
          hold_q[0] <= pclk_rise ? rgb_s : shift_q[0];
          for (int i = 1; i < COLS; i++)
            hold_q[i] <= pclk_rise ? shift_q[i-1] : shift_q[i];
        end else begin
          // Record in flight: the new row is dropped.
          err_overrun_q <= 1'b1;
        end
      end else begin
        pix_cnt_q <= pix_cnt_d;
      end

      unique case (state_q)
        ST_WAIT_OE: begin
          if (oe_rise) begin
            row_q    <= row_s;
            oe_cnt_q <= OE_CNT_WIDTH'(1);
          end
        end
        ST_MEASURE: begin
          if (oe_fall) begin
            oe_cycles_q <= oe_cnt_q;
            idx_q       <= COL_W'(COLS - 1);
          end else if (oe_level && oe_cnt_q != '1) begin
            oe_cnt_q <= oe_cnt_q + 1'b1;
          end
        end
        ST_DUMP: begin
          if (out_ready && idx_q != '0) idx_q <= idx_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Beat payload is driven straight from registers, so it holds while stalled.
  always_comb begin
    out_valid = 1'b0;
    out_col   = '0;
    out_rgb   = '0;
    out_last  = 1'b0;
    if (state_q == ST_DUMP) begin
      out_valid = 1'b1;
      out_col   = idx_q;
      out_rgb   = hold_q[idx_q];
      out_last  = (idx_q == '0);
    end
  end

  assign out_row       = row_q;
  assign out_oe_cycles = oe_cycles_q;
  assign pix_count     = pix_count_q;
  assign err_overrun   = err_overrun_q;
  assign err_length    = err_length_q;

endmodule

// File: tb/tb_hub75_row_capture.sv
// Directed bench for hub75_row_capture: a table of row scenarios plus
// hand-written sequences for overrun and mid-record reset.
module tb_hub75_row_capture;

  localparam int COLS = 64;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       panel_clk, panel_latch, panel_oe;
  logic [5:0] panel_rgb;
  logic [3:0] panel_row;
  logic       out_valid, out_ready, out_last;
  logic [5:0] out_col;
  logic [5:0] out_rgb;
  logic [3:0] out_row;
  logic [9:0] out_oe_cycles;
  logic [6:0] pix_count;
  logic       err_overrun, err_length;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of the capture shift register and the latched row.
  logic [5:0] exp_sr   [COLS];
  logic [5:0] exp_hold [COLS];

  typedef struct {
    int         n_pix;
    int         pat;       // 0: 63-k (column index), 1: (5k+1) mod 64
    logic [3:0] row;
    int         oe_len;
    bit         toggle;
    int         exp_pix;
    logic       exp_err_len;
    int         exp_oe;
  } vec_t;

  vec_t vecs [5];

  hub75_row_capture #(
    .COLS(64), .ROW_WIDTH(4), .OE_CNT_WIDTH(10), .SYNC_STAGES(2)
  ) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .panel_clk    (panel_clk),
    .panel_rgb    (panel_rgb),
    .panel_latch  (panel_latch),
    .panel_oe     (panel_oe),
    .panel_row    (panel_row),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_col      (out_col),
    .out_rgb      (out_rgb),
    .out_last     (out_last),
    .out_row      (out_row),
    .out_oe_cycles(out_oe_cycles),
    .pix_count    (pix_count),
    .err_overrun  (err_overrun),
    .err_length   (err_length)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_pixel(input logic [5:0] v);
    @(negedge clk_in);
    panel_rgb = v;
    panel_clk = 1'b0;
    repeat (2) @(negedge clk_in);
    panel_clk = 1'b1;
    repeat (2) @(negedge clk_in);
    panel_clk = 1'b0;
    for (int i = COLS - 1; i > 0; i--) exp_sr[i] = exp_sr[i-1];
    exp_sr[0] = v;
  endtask

  task automatic do_latch(input bit copy);
    @(negedge clk_in);
    panel_latch = 1'b1;
    repeat (2) @(negedge clk_in);
    panel_latch = 1'b0;
    repeat (6) @(negedge clk_in);
    if (copy) exp_hold = exp_sr;
  endtask

  // OE high for exactly n clk_in cycles at the pin; ends on a negedge.
  task automatic oe_pulse(input int n, input logic [3:0] row);
    @(negedge clk_in);
    panel_row = row;
    panel_oe  = 1'b1;
    repeat (n) @(negedge clk_in);
    panel_oe = 1'b0;
  endtask

  // Consumes beats, sampling on negedges; stop_at < COLS leaves the record open.
  task automatic collect(input bit toggle, input logic [3:0] exp_row,
                         input int exp_oe, input int stop_at);
    int beat = 0;
    int cyc = 0;
    int c;
    bit rdy = 1'b0;
    bit stalled = 1'b0;
    logic [5:0] s_col, s_rgb;
    logic s_last;
    while (!out_valid && cyc < 100) begin
      @(negedge clk_in);
      cyc++;
    end
    check("dump_start", {31'd0, out_valid}, 32'd1);
    if (!out_valid) return;
    check("out_row", {28'd0, out_row}, {28'd0, exp_row});
    check("out_oe_cycles", {22'd0, out_oe_cycles}, exp_oe);
    cyc = 0;
    while (beat < stop_at && cyc < 4 * COLS) begin
      if (stalled) begin
        check($sformatf("stall_col[%0d]", beat), {26'd0, out_col}, {26'd0, s_col});
        check($sformatf("stall_rgb[%0d]", beat), {26'd0, out_rgb}, {26'd0, s_rgb});
        check($sformatf("stall_last[%0d]", beat), {31'd0, out_last}, {31'd0, s_last});
        stalled = 1'b0;
      end
      rdy = toggle ? ~rdy : 1'b1;
      out_ready = rdy;
      if (rdy) begin
        c = COLS - 1 - beat;
        check($sformatf("valid[%0d]", beat), {31'd0, out_valid}, 32'd1);
        check($sformatf("col[%0d]", beat), {26'd0, out_col}, c);
        check($sformatf("rgb[%0d]", beat), {26'd0, out_rgb}, {26'd0, exp_hold[c]});
        check($sformatf("last[%0d]", beat), {31'd0, out_last}, (c == 0) ? 32'd1 : 32'd0);
        beat++;
      end else begin
        s_col   = out_col;
        s_rgb   = out_rgb;
        s_last  = out_last;
        stalled = 1'b1;
      end
      @(negedge clk_in);
      cyc++;
    end
    check("beat_count", beat, stop_at);
    if (stop_at == COLS) check("dump_end", {31'd0, out_valid}, 32'd0);
    out_ready = (stop_at == COLS);
  endtask

  task automatic run_row(input vec_t v, input logic exp_ovr);
    for (int k = 0; k < v.n_pix; k++)
      send_pixel(v.pat == 1 ? 6'((k * 5 + 1) & 63) : 6'((63 - k) & 63));
    do_latch(1'b1);
    check("pix_count", {25'd0, pix_count}, v.exp_pix);
    check("err_length", {31'd0, err_length}, {31'd0, v.exp_err_len});
    check("err_overrun", {31'd0, err_overrun}, {31'd0, exp_ovr});
    oe_pulse(v.oe_len, v.row);
    repeat (3) @(negedge clk_in);
    check("latency_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk_in);
    check("latency", {31'd0, out_valid}, 32'd1);
    collect(v.toggle, v.row, v.exp_oe, COLS);
  endtask

  initial begin
    vec_t rec;

    //         n_pix pat row    oe   tog  pix  errlen oe_exp
    vecs[0] = '{64,  0, 4'd5,  32,   1'b0, 64, 1'b0,  32};
    vecs[1] = '{64,  0, 4'd5,  32,   1'b1, 64, 1'b0,  32};
    vecs[2] = '{60,  1, 4'd9,  10,   1'b0, 60, 1'b1,  10};
    vecs[3] = '{70,  1, 4'd2,  5,    1'b0, 65, 1'b1,  5};
    vecs[4] = '{64,  0, 4'd7,  2000, 1'b0, 64, 1'b1,  1023};

    for (int i = 0; i < COLS; i++) begin
      exp_sr[i]   = '0;
      exp_hold[i] = '0;
    end
    reset       = 1'b1;
    panel_clk   = 1'b0;
    panel_latch = 1'b0;
    panel_oe    = 1'b0;
    panel_rgb   = '0;
    panel_row   = '0;
    out_ready   = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_pix_count", {25'd0, pix_count}, 32'd0);
    check("rst_err_overrun", {31'd0, err_overrun}, 32'd0);
    check("rst_err_length", {31'd0, err_length}, 32'd0);
    check("rst_out_row", {28'd0, out_row}, 32'd0);
    check("rst_out_oe", {22'd0, out_oe_cycles}, 32'd0);
    check("rst_out_col", {26'd0, out_col}, 32'd0);
    check("rst_out_rgb", {26'd0, out_rgb}, 32'd0);
    repeat (3) @(negedge clk_in);
    reset = 1'b1;
    repeat (2) @(negedge clk_in);

    for (int i = 0; i < 5; i++) run_row(vecs[i], 1'b0);

    // Overrun: a second latch while the record is stalled is dropped.
    out_ready = 1'b0;
    for (int k = 0; k < COLS; k++) send_pixel(6'(k) ^ 6'h2a);
    do_latch(1'b1);
    oe_pulse(8, 4'd3);
    repeat (10) @(negedge clk_in);
    check("ovr_in_dump", {31'd0, out_valid}, 32'd1);
    for (int k = 0; k < COLS; k++) send_pixel(6'(k));
    do_latch(1'b0);
    check("ovr_flag", {31'd0, err_overrun}, 32'd1);
    check("ovr_hold_col", {26'd0, out_col}, 32'd63);
    check("ovr_hold_rgb", {26'd0, out_rgb}, {26'd0, exp_hold[63]});
    collect(1'b0, 4'd3, 8, COLS);
    repeat (20) @(negedge clk_in);
    check("ovr_dropped", {31'd0, out_valid}, 32'd0);
    check("ovr_sticky", {31'd0, err_overrun}, 32'd1);

    // Reset in the middle of a record.
    rec = '{64, 1, 4'd11, 12, 1'b0, 64, 1'b1, 12};
    for (int k = 0; k < COLS; k++) send_pixel(6'((k * 5 + 1) & 63));
    do_latch(1'b1);
    oe_pulse(rec.oe_len, rec.row);
    collect(1'b0, rec.row, rec.exp_oe, 20);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_err_overrun", {31'd0, err_overrun}, 32'd0);
    check("mid_rst_err_length", {31'd0, err_length}, 32'd0);
    check("mid_rst_pix_count", {25'd0, pix_count}, 32'd0);
    check("mid_rst_out_row", {28'd0, out_row}, 32'd0);
    check("mid_rst_out_oe", {22'd0, out_oe_cycles}, 32'd0);
    check("mid_rst_out_col", {26'd0, out_col}, 32'd0);
    check("mid_rst_out_rgb", {26'd0, out_rgb}, 32'd0);
    for (int i = 0; i < COLS; i++) begin
      exp_sr[i]   = '0;
      exp_hold[i] = '0;
    end
    @(negedge clk_in);
    reset     = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk_in);
    rec.exp_err_len = 1'b0;
    run_row(rec, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
